// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the handshaking multi-cycle MIPS controller.
// State codes are visible on the debug port and must not be renumbered.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRtEx   = 4'd6,
    StRtWb   = 4'd7,
    StBeq    = 4'd8,
    StBne    = 4'd9,
    StIex    = 4'd10,
    StIwb    = 4'd11,
    StJmp    = 4'd12,
    StJal    = 4'd13
  } state_e;

  // ALU operation class handed from the FSM to the ALU decoder
  typedef enum logic [2:0] {
    AluOpNone,
    AluOpAdd,
    AluOpSub,
    AluOpFunct,
    AluOpImm
  } aluop_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam logic [1:0] MemToRegAlu  = 2'b00;
  localparam logic [1:0] MemToRegData = 2'b01;
  localparam logic [1:0] MemToRegPc   = 2'b10;

  localparam logic [1:0] RegDstRt = 2'b00;
  localparam logic [1:0] RegDstRd = 2'b01;
  localparam logic [1:0] RegDstRa = 2'b10;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef struct packed {
    logic       pcen;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       illegal;
    logic [1:0] memtoreg;
    logic [1:0] regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
  } ctrl_t;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's operation class plus op/funct to an ALU code.
// Also flags R-type funct values the datapath cannot execute.
module mc_aludec
  import mips_mc_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 3
) (
  input  aluop_e               aluop,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 zeroext,
  output logic                 funct_illegal
);

  logic [2:0] alu;

  always_comb begin
    funct_illegal = 1'b0;
    case (funct)
      FnAdd, FnSub, FnAnd, FnOr, FnSlt: funct_illegal = 1'b0;
      default:                          funct_illegal = 1'b1;
    endcase
  end

  always_comb begin
    alu     = AluAnd;
    zeroext = 1'b0;
    case (aluop)
      AluOpAdd: alu = AluAdd;
      AluOpSub: alu = AluSub;
      AluOpFunct: begin
        case (funct)
          FnAdd:   alu = AluAdd;
          FnSub:   alu = AluSub;
          FnAnd:   alu = AluAnd;
          FnOr:    alu = AluOr;
          FnSlt:   alu = AluSlt;
          default: alu = AluAnd;
        endcase
      end
      AluOpImm: begin
        case (op)
          OpAndi: begin
            alu     = AluAnd;
            zeroext = 1'b1;
          end
          OpOri: begin
            alu     = AluOr;
            zeroext = 1'b1;
          end
          OpSlti:  alu = AluSlt;
          default: alu = AluAdd;
        endcase
      end
      default: alu = AluAnd;
    endcase
  end

  assign alucontrol = ALUCTRL_W'(alu);

endmodule

// File: rtl/mips_mc_ctrl_hs.sv
// Multi-cycle MIPS control unit: Moore FSM with memory-ready handshake on every
// memory access, plus an illegal-instruction pulse for unknown op/funct.
module mips_mc_ctrl_hs
  import mips_mc_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 3,
  parameter int unsigned STATE_W   = 4,
  parameter int unsigned MEM_HS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pcen,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic                 iord,
  output logic                 zeroext,
  output logic [1:0]           memtoreg,
  output logic [1:0]           regdst,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal,
  output logic [STATE_W-1:0]   state
);

  state_e state_q, state_d;
  aluop_e aluop;
  ctrl_t  ctrl;
  logic   ready;
  logic   funct_illegal;

  assign ready = (MEM_HS != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Kept apart from the main decode so the ALU decoder feedback is loop-free
  always_comb begin
    aluop = AluOpNone;
    if (reset) begin
      case (state_q)
        StFetch, StDecode, StMemAdr: aluop = AluOpAdd;
        StRtEx:                      aluop = AluOpFunct;
        StBeq, StBne:                aluop = AluOpSub;
        StIex, StIwb:                aluop = AluOpImm;
        default:                     aluop = AluOpNone;
      endcase
    end
  end

  mc_aludec #(
    .ALUCTRL_W(ALUCTRL_W)
  ) u_aludec (
    .aluop        (aluop),
    .op           (op),
    .funct        (funct),
    .alucontrol   (alucontrol),
    .zeroext      (zeroext),
    .funct_illegal(funct_illegal)
  );

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    case (state_q)
      StFetch: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SrcBFour;
        // IR and PC only update once the instruction word is actually there
        ctrl.irwrite = ready;
        ctrl.pcen    = ready;
        if (ready) state_d = StDecode;
      end
      StDecode: begin
        ctrl.alusrcb = SrcBImmSh;
        case (op)
          OpLw, OpSw:                     state_d = StMemAdr;
          OpRtype:                        state_d = StRtEx;
          OpBeq:                          state_d = StBeq;
          OpBne:                          state_d = StBne;
          OpAddi, OpAndi, OpOri, OpSlti:  state_d = StIex;
          OpJ:                            state_d = StJmp;
          OpJal:                          state_d = StJal;
          default: begin
            ctrl.illegal = 1'b1;
            state_d      = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SrcBImm;
        state_d      = (op == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
        if (ready) state_d = StMemWb;
      end
      StMemWb: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = RegDstRt;
        ctrl.memtoreg = MemToRegData;
        state_d       = StFetch;
      end
      StMemWr: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
        if (ready) state_d = StFetch;
      end
      StRtEx: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SrcBReg;
        if (funct_illegal) begin
          ctrl.illegal = 1'b1;
          state_d      = StFetch;
        end else begin
          state_d = StRtWb;
        end
      end
      StRtWb: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = RegDstRd;
        ctrl.memtoreg = MemToRegAlu;
        state_d       = StFetch;
      end
      StBeq, StBne: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SrcBReg;
        ctrl.pcsrc   = PcSrcAluOut;
        ctrl.pcen    = (state_q == StBeq) ? zero : ~zero;
        state_d      = StFetch;
      end
      StIex: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SrcBImm;
        state_d      = StIwb;
      end
      StIwb: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = RegDstRt;
        ctrl.memtoreg = MemToRegAlu;
        state_d       = StFetch;
      end
      StJmp: begin
        ctrl.pcsrc = PcSrcJump;
        ctrl.pcen  = 1'b1;
        state_d    = StFetch;
      end
      StJal: begin
        ctrl.pcsrc    = PcSrcJump;
        ctrl.pcen     = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = RegDstRa;
        ctrl.memtoreg = MemToRegPc;
        state_d       = StFetch;
      end
      default: state_d = StFetch;
    endcase
    if (!reset) ctrl = '0;
  end

  assign pcen     = ctrl.pcen;
  assign memread  = ctrl.memread;
  assign memwrite = ctrl.memwrite;
  assign irwrite  = ctrl.irwrite;
  assign regwrite = ctrl.regwrite;
  assign alusrca  = ctrl.alusrca;
  assign iord     = ctrl.iord;
  assign memtoreg = ctrl.memtoreg;
  assign regdst   = ctrl.regdst;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign illegal  = ctrl.illegal;
  assign state    = STATE_W'(state_q);

endmodule
